// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared constants and the FSM state type for the sysbus
// bus-cycle controller.
//   WORD_W   - bus/data word width
//   OP_W     - opcode field width (upper bits of an address word)
//   ADDR_W   - word address width (WORD_W - OP_W)
//   BUF_ADDR - address of the switch buffer slave
//   state_t  - controller FSM states
package sysbus_pkg;

  localparam int unsigned WORD_W   = 10;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned ADDR_W   = WORD_W - OP_W;
  localparam int unsigned BUF_ADDR = 126;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sysbus_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, purely combinational.
//   i_req  [1:0] - request bits, bit i = requester i
//   i_last       - index of the previous owner
//   o_win  [1:0] - one-hot winner, all zero when nothing requests
// A lone requester always wins; on a tie the requester that did not own
// the bus last time wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_win
);

  always_comb begin
    o_win = '0;
    unique case (i_req)
      2'b01:   o_win = 2'b01;
      2'b10:   o_win = 2'b10;
      2'b11:   o_win = i_last ? 2'b01 : 2'b10;
      default: o_win = '0;
    endcase
  end

endmodule

// File: rtl/sysbus_ctrl.sv
// sysbus_ctrl: bus-cycle controller and two-way arbiter for the shared
// tri-state sysbus. Requester 0 is the CPU sequencer, requester 1 the
// decrypt engine. Each accepted access runs ADDR (address phase,
// load_MAR), DATA (MDR_bus for reads, driven write data with R_NW=0 for
// writes, stretched by bus_wait up to TIMEOUT cycles) and DONE (one-cycle
// done pulse with err/rdata).
// Ports:
//   clock, n_reset        - clock, synchronous active-low reset
//   req[1:0], rnw[1:0]    - per-requester request and direction (1=read)
//   addr0/addr1, wdata0/1 - per-requester address and write data
//   bus_wait              - slave stretch request during DATA
//   gnt[1:0], done[1:0]   - one-cycle grant / completion pulses
//   err, rdata            - completion status and read data, valid with done
//   busy                  - high whenever the FSM is not IDLE
//   sysbus                - shared tri-state bus
//   load_MAR, MDR_bus, R_NW - slave bus-cycle strobes
module sysbus_ctrl #(
  parameter int unsigned WORD_W  = sysbus_pkg::WORD_W,
  parameter int unsigned OP_W    = sysbus_pkg::OP_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 n_reset,
  input  logic [1:0]           req,
  input  logic [1:0]           rnw,
  input  logic [WORD_W-OP_W-1:0] addr0,
  input  logic [WORD_W-OP_W-1:0] addr1,
  input  logic [WORD_W-1:0]    wdata0,
  input  logic [WORD_W-1:0]    wdata1,
  input  logic                 bus_wait,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic                 err,
  output logic [WORD_W-1:0]    rdata,
  output logic                 busy,
  inout  wire  [WORD_W-1:0]    sysbus,
  output logic                 load_MAR,
  output logic                 MDR_bus,
  output logic                 R_NW
);

  import sysbus_pkg::*;

  localparam int unsigned AW    = WORD_W - OP_W;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic              r_owner;
  logic              r_last;
  logic              r_rnw;
  logic [AW-1:0]     r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_wcnt;

  logic [1:0]        r_gnt;
  logic [1:0]        r_done;
  logic              r_err;
  logic [WORD_W-1:0] r_rdata;
  logic              r_busy;
  logic              r_load_mar;
  logic              r_mdr_bus;
  logic              r_r_nw;
  logic              r_drv_en;
  logic [WORD_W-1:0] r_drv_val;

  logic [1:0]        w_win;
  logic              w_owner;
  logic [AW-1:0]     w_addr;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_tmo;

  rr_arb2 u_arb (
    .i_req  (req),
    .i_last (r_last),
    .o_win  (w_win)
  );

  assign w_owner   = w_win[1];
  assign w_addr    = w_owner ? addr1 : addr0;
  assign w_cnt_nxt = r_wcnt + 1'b1;
  assign w_tmo     = (w_cnt_nxt == CNT_W'(TIMEOUT));

  // All strobes and the bus enable are registered: each state's strobe
  // pattern is loaded on the edge that enters that state.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_rnw      <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wcnt     <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_load_mar <= 1'b0;
      r_mdr_bus  <= 1'b0;
      r_r_nw     <= 1'b1;
      r_drv_en   <= 1'b0;
      r_drv_val  <= '0;
    end else begin
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b1;
      r_load_mar <= 1'b0;
      r_mdr_bus  <= 1'b0;
      r_r_nw     <= 1'b1;
      r_drv_en   <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (|req) begin
            r_owner    <= w_owner;
            r_gnt      <= w_win;
            r_rnw      <= rnw[w_owner];
            r_addr     <= w_addr;
            r_wdata    <= w_owner ? wdata1 : wdata0;
            r_load_mar <= 1'b1;
            r_drv_en   <= 1'b1;
            r_drv_val  <= {{OP_W{1'b0}}, w_addr};
            r_state    <= ADDR;
          end else begin
            r_busy <= 1'b0;
          end
        end

        ADDR: begin
          r_wcnt    <= '0;
          r_mdr_bus <= r_rnw;
          r_r_nw    <= r_rnw;
          r_drv_en  <= ~r_rnw;
          r_drv_val <= r_wdata;
          r_state   <= DATA;
        end

        DATA: begin
          r_wcnt <= w_cnt_nxt;
          // A released bus_wait wins over the timeout in the same cycle.
          if (!bus_wait || w_tmo) begin
            r_done  <= r_owner ? 2'b10 : 2'b01;
            r_err   <= bus_wait;
            if (bus_wait)
              r_rdata <= '0;
            else if (r_rnw)
              r_rdata <= sysbus;
            r_state <= DONE;
          end else begin
            r_mdr_bus <= r_rnw;
            r_r_nw    <= r_rnw;
            r_drv_en  <= ~r_rnw;
            r_drv_val <= r_wdata;
          end
        end

        DONE: begin
          // R_NW rests at its inactive (read) level outside write DATA.
          r_last  <= r_owner;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign sysbus   = r_drv_en ? r_drv_val : {WORD_W{1'bz}};
  assign gnt      = r_gnt;
  assign done     = r_done;
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign busy     = r_busy;
  assign load_MAR = r_load_mar;
  assign MDR_bus  = r_mdr_bus;
  assign R_NW     = r_r_nw;

endmodule

// File: tb/tb_sysbus_ctrl.sv
module tb_sysbus_ctrl;
  import sysbus_pkg::*;

  localparam int unsigned TMO = 15;
  localparam int unsigned AW  = WORD_W - OP_W;

  logic              clock = 1'b0;
  logic              n_reset;
  logic [1:0]        req, rnw;
  logic [AW-1:0]     addr0, addr1;
  logic [WORD_W-1:0] wdata0, wdata1;
  logic              bus_wait;
  logic [1:0]        gnt, done;
  logic              err, busy, load_MAR, MDR_bus, R_NW;
  logic [WORD_W-1:0] rdata;
  wire  [WORD_W-1:0] sysbus;

  // bench-side slave: drives the bus whenever the controller must not
  logic              tb_en  = 1'b1;
  logic [WORD_W-1:0] tb_val = '0;
  logic [WORD_W-1:0] slave_val;
  assign sysbus = tb_en ? tb_val : {WORD_W{1'bz}};

  always #5 clock = ~clock;

  sysbus_ctrl #(.WORD_W(WORD_W), .OP_W(OP_W), .TIMEOUT(TMO)) dut (
    .clock(clock), .n_reset(n_reset), .req(req), .rnw(rnw),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .bus_wait(bus_wait), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .busy(busy), .sysbus(sysbus), .load_MAR(load_MAR), .MDR_bus(MDR_bus),
    .R_NW(R_NW)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Model: m_t = cycles since the grant cycle (-1 when no access),
  // m_dlen = number of DATA cycles once the data phase has ended (0 before).
  int                m_t     = -1;
  int                m_dlen  = 0;
  logic              m_last  = 1'b1;
  logic              m_owner = 1'b0;
  logic              m_rnw   = 1'b1;
  logic              m_err   = 1'b0;
  logic [AW-1:0]     m_addr  = '0;
  logic [WORD_W-1:0] m_wdata = '0;
  logic [WORD_W-1:0] m_rdata = '0;
  logic              m_valid = 1'b0;

  function automatic logic m_in_data();
    return (m_t >= 1) && (m_dlen == 0);
  endfunction

  function automatic logic m_drives();
    return (m_t == 0) || (m_in_data() && !m_rnw);
  endfunction

  always @(posedge clock) begin
    if (!n_reset) begin
      m_t = -1; m_dlen = 0; m_last = 1'b1; m_rdata = '0;
    end else if (m_t < 0) begin
      if (req != 2'b00) begin
        m_owner = (req == 2'b11) ? !m_last : req[1];
        m_rnw   = rnw[m_owner];
        m_addr  = m_owner ? addr1 : addr0;
        m_wdata = m_owner ? wdata1 : wdata0;
        m_t = 0; m_dlen = 0;
      end
    end else if (m_t == 0) begin
      m_t = 1;
    end else if (m_dlen == 0) begin
      if (!bus_wait || m_t == TMO) begin
        m_dlen = m_t;
        m_err  = bus_wait;
        if (bus_wait) m_rdata = '0;
        else if (m_rnw) m_rdata = slave_val;
      end
      m_t++;
    end else begin
      m_t = -1; m_last = m_owner;
    end
    m_valid = 1'b1;
    tb_en  <= !m_drives();
    tb_val <= (m_in_data() && m_rnw) ? slave_val : '0;
  end

  always @(negedge clock) begin
    if (m_valid) begin
      logic [1:0]        e_one;
      logic              e_done;
      logic [WORD_W-1:0] e_bus;
      e_one  = m_owner ? 2'b10 : 2'b01;
      e_done = (m_dlen != 0) && (m_t == m_dlen + 1);
      if (m_t == 0)                   e_bus = WORD_W'(m_addr);
      else if (m_drives())            e_bus = m_wdata;
      else if (m_in_data() && m_rnw)  e_bus = slave_val;
      else                            e_bus = '0;
      check("m_gnt",   32'(gnt),      32'((m_t == 0) ? e_one : 2'b00));
      check("m_done",  32'(done),     32'(e_done ? e_one : 2'b00));
      check("m_err",   32'(err),      32'(e_done && m_err));
      check("m_busy",  32'(busy),     32'(m_t >= 0));
      check("m_mar",   32'(load_MAR), 32'(m_t == 0));
      check("m_mdr",   32'(MDR_bus),  32'(m_in_data() && m_rnw));
      check("m_rnw",   32'(R_NW),     32'(!(m_in_data() && !m_rnw)));
      check("m_rdata", 32'(rdata),    32'(m_rdata));
      check("m_bus",   32'(sysbus),   32'(e_bus));
    end
  end

  task automatic wait_done(input string name, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(negedge clock);
      if (done != 2'b00) break;
    end
    check(name, 32'(i < maxc), 32'd1);
  endtask

  initial begin
    int gc[3];
    logic [1:0] gw[3];
    int ng, nd, g0, d0;
    logic hit;

    n_reset = 1'b0; req = 2'b11; rnw = 2'b00; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; bus_wait = 1'b0; slave_val = '0;

    // reset held for 3 edges with both requesting
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_gnt",   32'(gnt),      32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_rnw",   32'(R_NW),     32'd1);
    check("rst_mar",   32'(load_MAR), 32'd0);
    check("rst_rdata", 32'(rdata),    32'd0);
    check("rst_bus",   32'(sysbus),   32'd0);
    n_reset = 1'b1; req = 2'b00;
    @(negedge clock);

    // single read by requester 0 from the switch buffer
    req = 2'b01; rnw = 2'b01; addr0 = AW'(BUF_ADDR); slave_val = 10'h2A5;
    @(negedge clock);
    check("rd_gnt", 32'(gnt), 32'h1);
    check("rd_mar", 32'(load_MAR), 32'd1);
    check("rd_bus", 32'(sysbus), 32'h07E);
    req = 2'b00;
    @(negedge clock);
    check("rd_mdr", 32'(MDR_bus), 32'd1);
    @(negedge clock);
    check("rd_done",  32'(done),  32'h1);
    check("rd_rdata", 32'(rdata), 32'h2A5);
    check("rd_err",   32'(err),   32'd0);
    @(negedge clock);
    check("rd_idle", 32'(busy), 32'd0);

    // single write by requester 1
    req = 2'b10; rnw = 2'b00; addr1 = 7'd5; wdata1 = 10'h155;
    @(negedge clock);
    check("wr_gnt", 32'(gnt), 32'h2);
    check("wr_abus", 32'(sysbus), 32'h005);
    req = 2'b00;
    @(negedge clock);
    check("wr_dbus", 32'(sysbus), 32'h155);
    check("wr_rnw",  32'(R_NW),   32'd0);
    @(negedge clock);
    check("wr_done", 32'(done), 32'h2);
    @(negedge clock);

    // both requesting continuously: alternate owners, 4 cycles apart
    req = 2'b11; rnw = 2'b11; addr0 = 7'd1; addr1 = 7'd2; slave_val = 10'h003;
    ng = 0;
    for (int i = 0; i < 20 && ng < 3; i++) begin
      @(negedge clock);
      if (gnt != 2'b00) begin gw[ng] = gnt; gc[ng] = cyc; ng++; end
    end
    req = 2'b00;
    check("rr_count", 32'(ng), 32'd3);
    if (ng == 3) begin
      check("rr_g0", 32'(gw[0]), 32'h1);
      check("rr_g1", 32'(gw[1]), 32'h2);
      check("rr_g2", 32'(gw[2]), 32'h1);
      check("rr_gap1", 32'(gc[1] - gc[0]), 32'd4);
      check("rr_gap2", 32'(gc[2] - gc[1]), 32'd4);
    end
    wait_done("rr_wait", 10);
    @(negedge clock);

    // permanent bus_wait: timeout after TMO DATA cycles
    req = 2'b10; rnw = 2'b10; addr1 = AW'(BUF_ADDR); slave_val = 10'h1FF; bus_wait = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (gnt != 2'b00) req = 2'b00;
      if (MDR_bus) nd++;
      if (done != 2'b00) break;
    end
    check("to_ndata", 32'(nd),    32'd15);
    check("to_done",  32'(done),  32'h2);
    check("to_err",   32'(err),   32'd1);
    check("to_rdata", 32'(rdata), 32'd0);
    bus_wait = 1'b0;
    @(negedge clock);

    // bus_wait high for 3 DATA cycles: DATA lasts 4, done 3 cycles late
    req = 2'b01; rnw = 2'b01; addr0 = AW'(BUF_ADDR); slave_val = 10'h3C3; bus_wait = 1'b1;
    nd = 0; g0 = 0; d0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (gnt != 2'b00) begin g0 = cyc; req = 2'b00; end
      if (MDR_bus) begin nd++; if (nd == 4) bus_wait = 1'b0; end
      if (done != 2'b00) begin d0 = cyc; break; end
    end
    check("wt_ndata", 32'(nd),      32'd4);
    check("wt_lat",   32'(d0 - g0), 32'd5);
    check("wt_err",   32'(err),     32'd0);
    check("wt_rdata", 32'(rdata),   32'h3C3);
    bus_wait = 1'b0;
    @(negedge clock);

    // reset during read DATA of requester 1
    req = 2'b10; rnw = 2'b10; addr1 = AW'(BUF_ADDR); slave_val = 10'h0AA;
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (gnt != 2'b00) req = 2'b00;
      if (MDR_bus) begin n_reset = 1'b0; hit = 1'b1; break; end
    end
    check("rs_hit", 32'(hit), 32'd1);
    @(negedge clock);
    check("rs_busy", 32'(busy),    32'd0);
    check("rs_done", 32'(done),    32'd0);
    check("rs_mdr",  32'(MDR_bus), 32'd0);
    check("rs_bus",  32'(sysbus),  32'd0);
    n_reset = 1'b1; req = 2'b11; rnw = 2'b00; wdata0 = 10'h111; wdata1 = 10'h222;
    @(negedge clock);
    check("rs_tie", 32'(gnt), 32'h1);
    req = 2'b00;
    wait_done("rs_wait", 10);
    repeat (2) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sysbus_ctrl.md
# sysbus_ctrl

Bus-cycle controller and two-way arbiter for the shared `sysbus`. It accepts word read/write requests from two masters: requester 0, the CPU sequencer, and requester 1, the XOR/XNOR decrypt engine. It grants them in round-robin order and sequences each access into the address phase (`load_MAR`) and data phase (`MDR_bus` / `R_NW`) expected by memory-mapped slaves, including the switch buffer at address 126.

## Interface
- `WORD_W`, 10, bus/data word width
- `OP_W`, 3, opcode field width; address width `ADDR_W = WORD_W-OP_W` (7)
- `TIMEOUT`, 15, maximum data-phase length in cycles before abort (≥1)

- `clock`  in  1  system clock; one clock, all state on rising edge
- `n_reset`  in  1  synchronous, active-low reset
- `req`  in  2  per-requester access request (bit i = requester i)
- `rnw`  in  2  per-requester direction: 1 read, 0 write
- `addr0`, `addr1`  in  ADDR_W  per-requester word address
- `wdata0`, `wdata1`  in  WORD_W  per-requester write data
- `bus_wait`  in  1  slave stretch request during data phase
- `gnt`  out  2  one-hot, high for one cycle when a request is accepted
- `done`  out  2  one-hot, one-cycle completion pulse to the owning requester
- `err`  out  1  valid with `done`: 1 = timed-out access
- `rdata`  out  WORD_W  read data, valid with `done` on reads
- `busy`  out  1  high in every state except IDLE
- `sysbus`  inout  WORD_W  shared tri-state bus
- `load_MAR`, `MDR_bus`, `R_NW`  out  1  bus-cycle strobes to slaves

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If any `req` bit is high, the arbiter picks the owner.
  - `gnt[owner]` is registered.
  - `addr`, `wdata` and `rnw` of the owner are latched.
  - Next state is ADDR. With no request, the FSM stays in IDLE.
- Arbitration is round-robin on `last` (the last owner).
  - With both bits requesting, the non-`last` requester wins.
  - With one bit requesting, that requester wins regardless of `last`.
  - `last` resets to 1, so requester 0 wins the first tie.
- ADDR (1 cycle):
  - `sysbus` is driven with `{OP_W'b0, addr}`, `load_MAR=1`, `R_NW=1`.
  - Next state is DATA.
- DATA, read:
  - `sysbus` is released, `MDR_bus=1`, `R_NW=1`.
  - `sysbus` is sampled into `rdata` on the edge leaving DATA.
- DATA, write:
  - `sysbus` is driven with the latched wdata, `R_NW=0`, `MDR_bus=0`.
- DATA exit:
  - DATA persists while `bus_wait=1`.
  - A wait counter (width `$clog2(TIMEOUT+1)`) counts DATA cycles.
  - DATA exits when `bus_wait=0`, or when the count reaches `TIMEOUT`. On timeout, set `err=1` and force `rdata=0`.
- DONE (1 cycle):
  - `done[owner]=1`, and `err` and `rdata` are valid.
  - All strobes are low and `sysbus` is released.
  - `last` is updated to the owner; next state is IDLE.
- Requesters may drop `req` any time after `gnt`, because the latched values are used. A `req` still high after `done` is treated as a new request.
- Outside ADDR and write-DATA, `sysbus` is `'z`. The block never drives the bus during read DATA.
- Reset values: state IDLE, `gnt=0`, `done=0`, `err=0`, `rdata=0`, `busy=0`, `load_MAR=0`, `MDR_bus=0`, `R_NW=1`, `sysbus='z`, `last=1`, wait counter 0.

## Timing
- `req` high at edge k (FSM in IDLE):
  - `gnt` and ADDR occupy cycle k+1.
  - DATA occupies cycle k+2, with no wait.
  - `done` and `rdata` are valid in cycle k+3.
  - The FSM is back in IDLE in cycle k+4.
- Minimum spacing is 4 cycles per access. Back-to-back from both requesters alternates owners.
- Each `bus_wait` cycle adds one DATA cycle. Timeout gives `done` exactly `TIMEOUT` DATA cycles after DATA entry.
- `n_reset` low at any edge:
  - Next cycle is reset state.
  - An in-flight access is aborted with no `done`.
  - Any slave MAR keeps whatever was loaded.
- Simultaneous `req` change and `done`: only the IDLE-state sampling matters.

## Structure
- Package `sysbus_pkg` holds:
  - `WORD_W`, `OP_W` and `ADDR_W` constants.
  - `BUF_ADDR = 126` (switch buffer address).
  - The `state_t` enum {IDLE, ADDR, DATA, DONE}.
- Sub-module `rr_arb2` is purely combinational: it takes `req[1:0]` and `last`, and gives a one-hot winner. It is instantiated once.
- The FSM, latches, wait counter and tri-state driver live in the top level.

## Test plan
- Reset: hold `n_reset=0` for 3 edges with `req=2'b11` → all outputs at reset values, `sysbus` is `'z`, no `gnt`.
- Single read, requester 0, `addr0=126`, buffer switches `10'h2A5`:
  - `load_MAR` and bus `10'h07E` appear at k+1.
  - `MDR_bus` appears at k+2.
  - `done=2'b01` with `rdata=10'h2A5` and `err=0` at k+3.
- Single write, requester 1, `addr1=5`, `wdata1=10'h155` → bus `10'h005` at k+1, then bus `10'h155` with `R_NW=0` at k+2, then `done=2'b10`.
- `req=2'b11` held for 3 accesses → `gnt` sequence 01, 10, 01, with successive grants 4 cycles apart.
- `bus_wait` high for 3 DATA cycles → DATA lasts 4 cycles, `done` is 3 cycles late, `err=0`. Holding `bus_wait` high permanently → `done` with `err=1` and `rdata=0` after 15 DATA cycles.
- Reset asserted during DATA of a read → next cycle IDLE, no `done`, `sysbus` is `'z`, and the next tie goes to requester 0.
